// File: rtl/regfile_mp.sv
// regfile_mp: MIPS ID-stage register file, 2 comb read ports, 1 write port,
// optional zero register and sweep-clear FSM.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   clear_req             pulse: start a clear sweep (ignored while busy)
//   IF_ID_instr_rs/rt     read addresses
//   RegWrite              write enable (MEM/WB)
//   MEM_WB_Writereg/data  write address / data
//   readdat1/readdat2     combinational read data
//   busy                  high while the clear sweep runs
//
// Option macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_req,
   input  logic [ADDR_W-1:0] IF_ID_instr_rs,
   input  logic [ADDR_W-1:0] IF_ID_instr_rt,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] MEM_WB_Writereg,
   input  logic [DATA_W-1:0] MEM_WB_Writedata,
   output logic [DATA_W-1:0] readdat1,
   output logic [DATA_W-1:0] readdat2,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   clr_ptr, clr_ptr_d;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              user_wr;

   // No reset on the array so it maps onto distributed RAM.
   logic [DATA_W-1:0] regs [DEPTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state_q <= state_d;
         clr_ptr <= clr_ptr_d;
      end
   end

   // A user write to r0 is dropped when r0 is hardwired.
   assign user_wr = RegWrite &&
                    !(ZERO_REG && (MEM_WB_Writereg == '0));

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr;
      wr_en     = 1'b0;
      wr_addr   = MEM_WB_Writereg;
      wr_data   = MEM_WB_Writedata;
      busy      = 1'b0;
      unique case (state_q)
         CLEAR: begin
            busy      = 1'b1;
            wr_en     = 1'b1;
            wr_addr   = clr_ptr[ADDR_W-1:0];
            wr_data   = '0;
            clr_ptr_d = clr_ptr + 1'b1;
            if (clr_ptr == LAST) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // A write offered with clear_req still commits.
            wr_en = user_wr;
            if (clear_req) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   logic hit1, hit2;

`ifdef REGFILE_BYPASS_EN
   assign hit1 = !busy && user_wr &&
                 (IF_ID_instr_rs == MEM_WB_Writereg);
   assign hit2 = !busy && user_wr &&
                 (IF_ID_instr_rt == MEM_WB_Writereg);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   always_comb begin
      readdat1 = regs[IF_ID_instr_rs];
      if (busy) begin
         readdat1 = '0;
      end else if (ZERO_REG && IF_ID_instr_rs == '0) begin
         readdat1 = '0;
      end else if (hit1) begin
         readdat1 = MEM_WB_Writedata;
      end
   end

   always_comb begin
      readdat2 = regs[IF_ID_instr_rt];
      if (busy) begin
         readdat2 = '0;
      end else if (ZERO_REG && IF_ID_instr_rt == '0) begin
         readdat2 = '0;
      end else if (hit2) begin
         readdat2 = MEM_WB_Writedata;
      end
   end

endmodule
